// File: rtl/cordic_entry_controller.sv
// Push-button entry controller for a CORDIC engine: debounces a raw button,
// steps through function/operand entry, issues start and latches the result.
module cordic_entry_controller #(
  parameter int unsigned               WIDTH          = 16,
  parameter int unsigned               FUNC_W         = 4,
  parameter int unsigned               DEBOUNCE_COUNT = 50000000,
  parameter logic [(2**FUNC_W)-1:0]    TWO_OP_MASK    = 'h0083,
  parameter int unsigned               TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st,
  input  logic [WIDTH-1:0]          sw_in,
  input  logic                      done,
  input  logic [2*WIDTH-1:0]        result,
  output logic [FUNC_W-1:0]         func,
  output logic signed [WIDTH-1:0]   op1,
  output logic signed [WIDTH-1:0]   op2,
  output logic                      start,
  output logic [2*WIDTH-1:0]        result_q,
  output logic [2:0]                state,
  output logic                      idle,
  output logic                      err
);

  localparam int unsigned DB_W = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_COUNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_ENTER1  = 3'd2,
    S_ENTER2  = 3'd3,
    S_READY   = 3'd4,
    S_COMPUTE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_db_level;
  logic [DB_W-1:0]          r_db_cnt;
  logic                     r_press;
  logic [TO_W-1:0]          r_to_cnt;
  logic [FUNC_W-1:0]        r_func;
  logic signed [WIDTH-1:0]  r_op1;
  logic signed [WIDTH-1:0]  r_op2;
  logic                     r_start;
  logic [2*WIDTH-1:0]       r_result_q;
  logic                     r_idle;
  logic                     r_err;

  logic w_timeout;
  logic w_ld_func;
  logic w_ld_op1;
  logic w_ld_op2;
  logic w_start_nxt;
  logic w_ld_res;
  logic w_set_err;
  logic w_to_inc;

  // Two-flop synchroniser, symmetric debounce and rising-edge press pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= st;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
        r_press    <= r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_timeout = (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_press) w_state_nxt = S_SELECT;
      S_SELECT:  if (r_press) w_state_nxt = S_ENTER1;
      S_ENTER1:  if (r_press) w_state_nxt = TWO_OP_MASK[r_func] ? S_ENTER2 : S_READY;
      S_ENTER2:  if (r_press) w_state_nxt = S_READY;
      S_READY:   if (r_press) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (done || w_timeout) w_state_nxt = S_DONE;
      S_DONE:    if (r_press) w_state_nxt = S_SELECT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Load enables for the registered outputs; done beats a coincident timeout
  always_comb begin
    w_ld_func   = 1'b0;
    w_ld_op1    = 1'b0;
    w_ld_op2    = 1'b0;
    w_start_nxt = 1'b0;
    w_ld_res    = 1'b0;
    w_set_err   = 1'b0;
    w_to_inc    = 1'b0;
    case (r_state)
      S_SELECT:  w_ld_func   = r_press;
      S_ENTER1:  w_ld_op1    = r_press;
      S_ENTER2:  w_ld_op2    = r_press;
      S_READY:   w_start_nxt = r_press;
      S_COMPUTE: begin
        w_ld_res  = done;
        w_set_err = !done && w_timeout;
        w_to_inc  = !done && !w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func     <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_start    <= 1'b0;
      r_result_q <= '0;
      r_idle     <= 1'b1;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_start <= w_start_nxt;
      r_idle  <= (w_state_nxt == S_IDLE);
      if (w_ld_func) r_func <= sw_in[FUNC_W-1:0];
      if (w_ld_op1)  r_op1  <= sw_in;
      if (w_ld_op2)  r_op2  <= sw_in;
      if (w_ld_res)  r_result_q <= result;
      if (w_ld_res)       r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
      if (w_start_nxt)   r_to_cnt <= '0;
      else if (w_to_inc) r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign func     = r_func;
  assign op1      = r_op1;
  assign op2      = r_op2;
  assign start    = r_start;
  assign result_q = r_result_q;
  assign state    = r_state;
  assign idle     = r_idle;
  assign err      = r_err;

endmodule

// File: tb/tb_cordic_entry_controller.sv
// Directed bench for cordic_entry_controller with a result/err scoreboard.
module tb_cordic_entry_controller;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FUNC_W = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     st = 1'b0;
  logic [WIDTH-1:0]         sw_in = '0;
  logic                     done = 1'b0;
  logic [2*WIDTH-1:0]       result = '0;
  logic [FUNC_W-1:0]        func;
  logic signed [WIDTH-1:0]  op1;
  logic signed [WIDTH-1:0]  op2;
  logic                     start;
  logic [2*WIDTH-1:0]       result_q;
  logic [2:0]               state;
  logic                     idle;
  logic                     err;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ok;

  cordic_entry_controller #(
    .WIDTH(WIDTH), .FUNC_W(FUNC_W), .DEBOUNCE_COUNT(4),
    .TWO_OP_MASK(16'h0083), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .st(st), .sw_in(sw_in), .done(done), .result(result),
    .func(func), .op1(op1), .op2(op2), .start(start), .result_q(result_q),
    .state(state), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    check({tag, " state"}, 64'(state), 64'd6);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed DONE with empty scoreboard, expected pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " result_q"}, 64'(result_q), 64'(e.res));
      check({tag, " err"}, 64'(err), 64'(e.err));
    end
  endtask

  task automatic press(input logic [WIDTH-1:0] sw);
    st = 1'b0;
    repeat (8) @(negedge clk);
    sw_in = sw;
    st = 1'b1;
    repeat (12) @(negedge clk);
    st = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Presses in READY and returns on the first COMPUTE cycle
  task automatic go_compute(input string tag, output bit found);
    found = 1'b0;
    st = 1'b0;
    repeat (8) @(negedge clk);
    st = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd5) found = 1'b1;
    end
    st = 1'b0;
    if (!found) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no COMPUTE within 40 cycles, expected state 5", tag);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst state", 64'(state), 64'd0);
    check("rst idle", 64'(idle), 64'd1);
    check("rst result_q", 64'(result_q), 64'd0);
    check("rst start", 64'(start), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Debounce: short pulse rejected, long hold with short gap gives one event
    st = 1'b1;
    repeat (3) @(negedge clk);
    st = 1'b0;
    repeat (15) @(negedge clk);
    check("db short pulse", 64'(state), 64'd0);
    st = 1'b1;
    repeat (40) @(negedge clk);
    st = 1'b0;
    repeat (3) @(negedge clk);
    st = 1'b1;
    repeat (57) @(negedge clk);
    st = 1'b0;
    repeat (12) @(negedge clk);
    check("db long hold", 64'(state), 64'd1);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Two-operand flow
    press(16'h0000);
    check("f1 select", 64'(state), 64'd1);
    check("f1 idle", 64'(idle), 64'd0);
    press(16'h0001);
    check("f1 enter1", 64'(state), 64'd2);
    check("f1 func", 64'(func), 64'd1);
    press(16'h1234);
    check("f1 enter2", 64'(state), 64'd3);
    check("f1 op1", 64'($unsigned(op1)), 64'h1234);
    press(16'hFF00);
    check("f1 ready", 64'(state), 64'd4);
    check("f1 op2", 64'($unsigned(op2)), 64'hFF00);
    check("f1 no start", 64'(start), 64'd0);
    go_compute("f1 go", ok);
    check("f1 start", 64'(start), 64'd1);
    done = 1'b1;
    result = 32'h0000ABCD;
    exp_q.push_back('{res: 32'h0000ABCD, err: 1'b0});
    @(negedge clk);
    done = 1'b0;
    result = '0;
    check("f1 start once", 64'(start), 64'd0);
    check_done("f1 done");

    // Single-operand flow, then timeout
    press(16'h0000);
    check("f2 select", 64'(state), 64'd1);
    press(16'h0002);
    check("f2 func", 64'(func), 64'd2);
    press(16'h0055);
    check("f2 skip enter2", 64'(state), 64'd4);
    check("f2 op1", 64'($unsigned(op1)), 64'h0055);
    check("f2 op2 kept", 64'($unsigned(op2)), 64'hFF00);
    go_compute("f2 go", ok);
    check("f2 start", 64'(start), 64'd1);
    exp_q.push_back('{res: 32'h0000ABCD, err: 1'b1});
    repeat (15) @(negedge clk);
    check("to still compute", 64'(state), 64'd5);
    @(negedge clk);
    check_done("to done");
    press(16'h0000);
    check("to reselect", 64'(state), 64'd1);
    check("to err held", 64'(err), 64'd1);

    // done outside COMPUTE is ignored
    done = 1'b1;
    result = 32'h00009999;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("stray done res", 64'(result_q), 64'h0000ABCD);
    check("stray done state", 64'(state), 64'd1);

    // done coincident with timeout
    press(16'h0007);
    check("f3 func", 64'(func), 64'd7);
    press(16'h1111);
    check("f3 enter2", 64'(state), 64'd3);
    press(16'h2222);
    check("f3 ready", 64'(state), 64'd4);
    go_compute("f3 go", ok);
    repeat (15) @(negedge clk);
    check("f3 last cycle", 64'(state), 64'd5);
    done = 1'b1;
    result = 32'h12345678;
    exp_q.push_back('{res: 32'h12345678, err: 1'b0});
    @(negedge clk);
    done = 1'b0;
    result = '0;
    check_done("f3 tie");

    // Reset mid-COMPUTE
    press(16'h0000);
    press(16'h0000);
    press(16'h0003);
    press(16'h0004);
    check("f4 ready", 64'(state), 64'd4);
    go_compute("f4 go", ok);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid rst state", 64'(state), 64'd0);
    check("mid rst idle", 64'(idle), 64'd1);
    check("mid rst func", 64'(func), 64'd0);
    check("mid rst op1", 64'($unsigned(op1)), 64'd0);
    check("mid rst op2", 64'($unsigned(op2)), 64'd0);
    check("mid rst result_q", 64'(result_q), 64'd0);
    check("mid rst err", 64'(err), 64'd0);
    check("mid rst start", 64'(start), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done = 1'b1;
    result = 32'h0000DEAD;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    check("late done state", 64'(state), 64'd0);
    check("late done res", 64'(result_q), 64'd0);
    check("late done start", 64'(start), 64'd0);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
